// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads ROM words one at a time, decodes the fields
// and hands each instruction to the execution controller via valid/done.
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter logic [3:0] INSTR_MEM_EN = 4'h1,
  parameter int         MEM_DEPTH    = 12,
  parameter int         PC_W         = 12
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            Start,
  output logic [15:0]     address,
  output logic            nRead,
  input  logic [31:0]     DataIn,
  output logic            InstrValid,
  output logic [7:0]      Opcode,
  output logic [7:0]      Dest,
  output logic [7:0]      Src1,
  output logic [7:0]      Src2,
  input  logic            ExecDone,
  output logic [PC_W-1:0] Pc,
  output logic            Halted,
  output logic            IllegalOp,
  output logic            Overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DISPATCH, HALT} state_t;

  localparam logic [PC_W:0] DEPTH = (PC_W+1)'(MEM_DEPTH);
  localparam logic [7:0]    STOP_OP = 8'hFF;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     address_next;
  logic            nread_next;
  logic            valid_next;
  logic [31:0]     word_next;
  logic            halted_next;
  logic            illegal_next;
  logic            overrun_next;
  logic [PC_W:0]   pc_inc;

  // One extra bit so running past the last word is detectable without wrap.
  assign pc_inc = {1'b0, Pc} + (PC_W+1)'(1);

  function automatic logic is_legal(input logic [7:0] op);
    return (op <= 8'h07) || ((op >= 8'h10) && (op <= 8'h13));
  endfunction

  always_comb begin
    state_next   = state;
    pc_next      = Pc;
    address_next = address;
    nread_next   = nRead;
    valid_next   = InstrValid;
    word_next    = {Opcode, Dest, Src1, Src2};
    halted_next  = Halted;
    illegal_next = IllegalOp;
    overrun_next = Overrun;

    case (state)
      IDLE: begin
        nread_next = 1'b1;
        if (Start) begin
          pc_next      = '0;
          address_next = 16'({INSTR_MEM_EN, {PC_W{1'b0}}});
          nread_next   = 1'b0;
          state_next   = FETCH;
        end
      end

      FETCH: begin
        word_next  = DataIn;
        nread_next = 1'b1;
        if (DataIn[31:24] == STOP_OP) begin
          halted_next = 1'b1;
          state_next  = HALT;
        end else if (is_legal(DataIn[31:24])) begin
          valid_next = 1'b1;
          state_next = DISPATCH;
        end else begin
          halted_next  = 1'b1;
          illegal_next = 1'b1;
          state_next   = HALT;
        end
      end

      DISPATCH: begin
        if (ExecDone) begin
          valid_next = 1'b0;
          if (pc_inc == DEPTH) begin
            // Pc stays on the last word so it reports where fetch stopped.
            halted_next  = 1'b1;
            overrun_next = 1'b1;
            state_next   = HALT;
          end else begin
            pc_next      = pc_inc[PC_W-1:0];
            address_next = 16'({INSTR_MEM_EN, pc_inc[PC_W-1:0]});
            nread_next   = 1'b0;
            state_next   = FETCH;
          end
        end
      end

      HALT: begin
        nread_next = 1'b1;
        valid_next = 1'b0;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state      <= IDLE;
      Pc         <= '0;
      address    <= 16'h0000;
      nRead      <= 1'b1;
      InstrValid <= 1'b0;
      Opcode     <= 8'h00;
      Dest       <= 8'h00;
      Src1       <= 8'h00;
      Src2       <= 8'h00;
      Halted     <= 1'b0;
      IllegalOp  <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      Pc         <= pc_next;
      address    <= address_next;
      nRead      <= nread_next;
      InstrValid <= valid_next;
      {Opcode, Dest, Src1, Src2} <= word_next;
      Halted     <= halted_next;
      IllegalOp  <= illegal_next;
      Overrun    <= overrun_next;
    end
  end

endmodule
